// File: rtl/tpu_weight_row_packer.sv
// Collects 8-weight ternary beats into 64-weight rows and emits one
// 128-bit row per write, either base-3 packed or raw 2-bit.
module tpu_weight_row_packer #(
    parameter int ARRAY_SIZE   = 64,
    parameter int BEAT_WEIGHTS = 8,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  packed_mode,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_weights,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [127:0]          out_data,
    output logic [15:0]           rows_done,
    output logic                  err_illegal
);

    generate
        if (ARRAY_SIZE != 64 || BEAT_WEIGHTS != 8) begin : g_bad_cfg
            $error("tpu_weight_row_packer: only 64x8 geometry supported");
        end
    endgenerate

    logic [127:0]          stage;
    logic [2:0]            beat_cnt;
    logic                  stage_full;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] row_idx;
    logic [15:0]           beat_clean;
    logic                  beat_bad;
    logic [127:0]          packed_row;
    logic                  accept;
    logic                  xfer;
    logic                  out_hs;

    // Digits use code value directly: 121 = sum of 3^i cancels the -1 offset.
    function automatic logic [127:0] pack_row(input logic [127:0] row);
        logic [129:0] ext;
        logic [127:0] res;
        logic [7:0]   acc;
        logic [7:0]   p3;
        logic [1:0]   d;
        ext = {2'b01, row};
        res = '0;
        for (int g = 0; g < 13; g++) begin
            acc = '0;
            p3  = 8'd1;
            for (int i = 0; i < 5; i++) begin
                d   = ext[2*(5*g+i) +: 2];
                acc = acc + {6'd0, d} * p3;
                p3  = p3 * 8'd3;
            end
            res[8*g +: 8] = acc;
        end
        return res;
    endfunction

    always_comb begin
        beat_clean = '0;
        beat_bad   = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (in_weights[2*l +: 2] == 2'b11) begin
                beat_clean[2*l +: 2] = 2'b01;
                beat_bad             = 1'b1;
            end else begin
                beat_clean[2*l +: 2] = in_weights[2*l +: 2];
            end
        end
    end

    assign packed_row = pack_row(stage);
    assign in_ready   = !stage_full;
    assign accept     = in_valid && in_ready;
    assign xfer       = stage_full && (!out_valid || out_ready);
    assign out_hs     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage       <= '0;
            beat_cnt    <= '0;
            stage_full  <= 1'b0;
            base_addr   <= '0;
            row_idx     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            rows_done   <= '0;
            err_illegal <= 1'b0;
        end else if (start) begin
            stage       <= '0;
            beat_cnt    <= '0;
            stage_full  <= 1'b0;
            base_addr   <= cfg_base_addr;
            row_idx     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            rows_done   <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (accept) begin
                // A short row pads every later beat slot with zero weights.
                for (int b = 0; b < 8; b++) begin
                    if (3'(b) == beat_cnt) begin
                        stage[16*b +: 16] <= beat_clean;
                    end else if (in_last && 3'(b) > beat_cnt) begin
                        stage[16*b +: 16] <= 16'h5555;
                    end
                end
                if (beat_cnt == 3'd7 || in_last) begin
                    stage_full <= 1'b1;
                end
                beat_cnt <= beat_cnt + 3'd1;
                if (beat_bad) begin
                    err_illegal <= 1'b1;
                end
            end
            if (xfer) begin
                out_data   <= packed_mode ? packed_row : stage;
                out_addr   <= base_addr + row_idx;
                row_idx    <= row_idx + 1'b1;
                out_valid  <= 1'b1;
                stage_full <= 1'b0;
                beat_cnt   <= '0;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs) begin
                rows_done <= rows_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tpu_weight_row_packer.sv
// Randomized scoreboard bench for tpu_weight_row_packer against an
// integer base-3 reference model.
module tb_tpu_weight_row_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         packed_mode;
    logic [11:0]  cfg_base_addr;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_weights;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [11:0]  out_addr;
    logic [127:0] out_data;
    logic [15:0]  rows_done;
    logic         err_illegal;

    tpu_weight_row_packer #(
        .ARRAY_SIZE(64),
        .BEAT_WEIGHTS(8),
        .ADDR_WIDTH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .packed_mode(packed_mode),
        .cfg_base_addr(cfg_base_addr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_weights(in_weights),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_data(out_data),
        .rows_done(rows_done),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [11:0]  addr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   hs_cnt = 0;
    int   row_n = 0;
    int   ready_mode = 0;
    logic [11:0] base_m = '0;
    logic err_m = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit has_bad(input logic [15:0] bw);
        bit r;
        r = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (bw[2*l +: 2] == 2'b11) r = 1'b1;
        end
        return r;
    endfunction

    // Weights as signed integers, bytes as 121 + sum s*3^i.
    function automatic logic [127:0] model_row(input logic [15:0] beats[8],
                                               input int nb, input bit pk);
        int s[65];
        logic [15:0]  bw;
        logic [1:0]   c;
        logic [127:0] r;
        int v;
        int p;
        r = '0;
        for (int k = 0; k < 65; k++) begin
            s[k] = 0;
            if (k < nb * 8) begin
                bw = beats[k/8];
                c  = bw[2*(k%8) +: 2];
                if (c == 2'b00) s[k] = -1;
                else if (c == 2'b10) s[k] = 1;
            end
        end
        if (pk) begin
            for (int g = 0; g < 13; g++) begin
                v = 121;
                p = 1;
                for (int i = 0; i < 5; i++) begin
                    v = v + s[5*g+i] * p;
                    p = p * 3;
                end
                r[8*g +: 8] = 8'(v);
            end
        end else begin
            for (int k = 0; k < 64; k++) begin
                r[2*k +: 2] = 2'(s[k] + 1);
            end
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last);
        bit r;
        int n;
        in_valid   = 1'b1;
        in_weights = d;
        in_last    = last;
        n = 0;
        forever begin
            r = in_ready;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 300) begin
                chk("beat_accept_timeout", 128'(in_ready), 128'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_row(input logic [15:0] beats[8], input int nb,
                            input bit last_flag, input bit pk,
                            input int gap_max);
        exp_t e;
        wait_ready();
        packed_mode = pk;
        for (int b = 0; b < nb; b++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_beat(beats[b], (b == nb - 1) && last_flag);
            if (has_bad(beats[b])) err_m = 1'b1;
        end
        e.data = model_row(beats, nb, pk);
        e.addr = base_m + 12'(row_n);
        q.push_back(e);
        row_n++;
        chk("err_illegal", 128'(err_illegal), 128'(err_m));
    endtask

    task automatic do_start(input logic [11:0] base);
        cfg_base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        base_m = base;
        row_n  = 0;
        hs_cnt = 0;
        err_m  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 128'(q.size()), 128'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // out_ready changes just after posedge so the monitor sees it settled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        exp_t         e;
        bit           held;
        logic [127:0] pd;
        logic [11:0]  pa;
        held = 1'b0;
        pd = '0;
        pa = '0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (held) begin
                    chk("stall_data_stable", out_data, pd);
                    chk("stall_addr_stable", 128'(out_addr), 128'(pa));
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_row", 128'(out_valid), 128'd0);
                    end else begin
                        e = q.pop_front();
                        chk("row_data", out_data, e.data);
                        chk("row_addr", 128'(out_addr), 128'(e.addr));
                        chk("rows_done", 128'(rows_done), 128'(16'(hs_cnt)));
                    end
                    hs_cnt++;
                end else begin
                    held = 1'b1;
                    pd = out_data;
                    pa = out_addr;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bt[8];
        logic [15:0] w;
        int nb;
        bit lf;
        rst = 1'b1;
        start = 1'b0;
        packed_mode = 1'b1;
        cfg_base_addr = '0;
        in_valid = 1'b0;
        in_weights = '0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_addr", 128'(out_addr), 128'd0);
        chk("rst_rows_done", 128'(rows_done), 128'd0);
        chk("rst_err", 128'(err_illegal), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        do_start(12'h010);
        foreach (bt[i]) bt[i] = 16'h5555;
        send_row(bt, 8, 1'b0, 1'b1, 0);
        foreach (bt[i]) bt[i] = 16'hAAAA;
        send_row(bt, 8, 1'b0, 1'b1, 0);
        foreach (bt[i]) bt[i] = 16'h0000;
        send_row(bt, 8, 1'b0, 1'b1, 0);
        foreach (bt[i]) bt[i] = 16'h1111 * 16'(i + 1);
        send_row(bt, 8, 1'b0, 1'b0, 0);
        foreach (bt[i]) bt[i] = 16'hAAAA;
        send_row(bt, 3, 1'b1, 1'b1, 0);
        drain();
        chk("rows_done_total", 128'(rows_done), 128'(row_n));

        do_start(12'h040);
        ready_mode = 2;
        @(negedge clk);
        foreach (bt[i]) bt[i] = 16'(16'h1234 + i);
        send_row(bt, 8, 1'b0, 1'b0, 0);
        foreach (bt[i]) bt[i] = 16'(16'h9182 ^ i);
        send_row(bt, 8, 1'b0, 1'b1, 0);
        repeat (30) @(negedge clk);
        chk("stall_in_ready", 128'(in_ready), 128'd0);
        chk("stall_out_valid", 128'(out_valid), 128'd1);
        chk("stall_out_addr", 128'(out_addr), 128'h040);
        ready_mode = 0;
        drain();

        do_start(12'h100);
        foreach (bt[i]) bt[i] = 16'h5555;
        bt[0] = 16'h5575;
        send_row(bt, 8, 1'b0, 1'b1, 0);
        drain();
        send_beat(16'h5555, 1'b0);
        send_beat(16'h5555, 1'b0);
        send_beat(16'h5555, 1'b0);
        in_valid = 1'b1;
        in_weights = 16'hAAAA;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        row_n = 0;
        hs_cnt = 0;
        err_m = 1'b0;
        base_m = '0;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_err", 128'(err_illegal), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        do_start(12'h020);
        foreach (bt[i]) bt[i] = 16'(16'h4242 + 16'h0101 * i);
        send_row(bt, 8, 1'b0, 1'b0, 0);
        drain();

        do_start(12'hFFC);
        ready_mode = 1;
        for (int r = 0; r < 40; r++) begin
            foreach (bt[i]) begin
                w = '0;
                for (int l = 0; l < 8; l++) begin
                    if ($urandom_range(0, 99) < 3) w[2*l +: 2] = 2'b11;
                    else w[2*l +: 2] = 2'($urandom_range(0, 2));
                end
                bt[i] = w;
            end
            nb = $urandom_range(1, 8);
            lf = (nb < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            send_row(bt, nb, lf, 1'($urandom_range(0, 1)), 2);
        end
        drain();
        ready_mode = 0;
        chk("rand_rows_done", 128'(rows_done), 128'(row_n));
        chk("rand_err_final", 128'(err_illegal), 128'(err_m));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
